// File: rtl/rgen_pkg.sv
// ---------------------------------------------------------------------------
// rgen_pkg
// Shared definitions for the generated register block host interfaces.
//   rgen_host_if_state_e : host interface FSM states (2-bit encoding)
//   RGEN_APB_WAIT_STATES : number of wait states inserted per APB transfer
// ---------------------------------------------------------------------------
package rgen_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COMMAND  = 2'd1,
      RESPONSE = 2'd2
   } rgen_host_if_state_e;

   localparam int RGEN_APB_WAIT_STATES = 1;

endpackage

// File: rtl/rgen_read_data_mux.sv
// ---------------------------------------------------------------------------
// rgen_read_data_mux
// Combinational read-data return path shared by the host interfaces.
// Each register's read data is masked by its select and the results are
// OR-ed together; hit reports that at least one register is selected.
//   select    : per-register select from the address decoders
//   read_data : packed read data, register n at [n*DATA_WIDTH +: DATA_WIDTH]
//   data      : OR of all selected registers' read data
//   hit       : OR-reduction of select
// ---------------------------------------------------------------------------
module rgen_read_data_mux #(
   parameter int DATA_WIDTH      = 32,
   parameter int TOTAL_REGISTERS = 1
) (
   input  logic [TOTAL_REGISTERS-1:0]            select,
   input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] read_data,
   output logic [DATA_WIDTH-1:0]                 data,
   output logic                                  hit
);

   // Multiple selects simply OR their data; the decoders are trusted to be
   // one-hot and overlap is deliberately not flagged here.
   always_comb begin
      data = '0;
      for (int n = 0; n < TOTAL_REGISTERS; n++) begin
         if (select[n]) begin
            data = data | read_data[n*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign hit = |select;

endmodule

// File: rtl/rgen_host_if_apb.sv
// ---------------------------------------------------------------------------
// rgen_host_if_apb
// APB3 slave front end for the generated register block. Each APB transfer
// becomes a one-cycle internal command (address, read/write strobe, write
// data); the decoders' selects and register read data are then folded into
// PRDATA/PSLVERR with PREADY raised after a fixed single wait state.
// All outputs are registered.
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_psel .. i_pwdata    : APB request
//   o_pready/o_prdata/
//   o_pslverr             : APB response
//   o_address, o_read,
//   o_write, o_write_data : internal command to the decoders
//   i_register_select     : per-register select from the decoders
//   i_register_read_data  : packed per-register read data
// ---------------------------------------------------------------------------
module rgen_host_if_apb
   import rgen_pkg::*;
#(
   parameter int ADDRESS_WIDTH   = 16,
   parameter int DATA_WIDTH      = 32,
   parameter int TOTAL_REGISTERS = 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  i_psel,
   input  logic                                  i_penable,
   input  logic                                  i_pwrite,
   input  logic [ADDRESS_WIDTH-1:0]              i_paddr,
   input  logic [DATA_WIDTH-1:0]                 i_pwdata,
   output logic                                  o_pready,
   output logic [DATA_WIDTH-1:0]                 o_prdata,
   output logic                                  o_pslverr,
   output logic [ADDRESS_WIDTH-1:0]              o_address,
   output logic                                  o_read,
   output logic                                  o_write,
   output logic [DATA_WIDTH-1:0]                 o_write_data,
   input  logic [TOTAL_REGISTERS-1:0]            i_register_select,
   input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_register_read_data
);

   localparam logic [1:0] ST_IDLE     = 2'(IDLE);
   localparam logic [1:0] ST_COMMAND  = 2'(COMMAND);
   localparam logic [1:0] ST_RESPONSE = 2'(RESPONSE);

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] mux_data;
   logic                  mux_hit;

   rgen_read_data_mux #(
      .DATA_WIDTH      (DATA_WIDTH),
      .TOTAL_REGISTERS (TOTAL_REGISTERS)
   ) u_read_data_mux (
      .select    (i_register_select),
      .read_data (i_register_read_data),
      .data      (mux_data),
      .hit       (mux_hit)
   );

   // Transfer sequencer. The command strobe occupies the single COMMAND
   // cycle, which doubles as the wait state; the response is captured at the
   // end of it so the decoders have a full cycle to settle their selects.
   // A master abort in COMMAND drops the response but cannot retract a
   // write that has already been strobed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         o_read       <= 1'b0;
         o_write      <= 1'b0;
         o_pready     <= 1'b0;
         o_pslverr    <= 1'b0;
         o_address    <= '0;
         o_write_data <= '0;
         o_prdata     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_psel && !i_penable) begin
                  o_address    <= i_paddr;
                  o_write_data <= i_pwdata;
                  o_read       <= !i_pwrite;
                  o_write      <= i_pwrite;
                  state        <= ST_COMMAND;
               end
            end
            ST_COMMAND: begin
               o_read  <= 1'b0;
               o_write <= 1'b0;
               if (!i_psel) begin
                  state <= ST_IDLE;
               end else begin
                  o_prdata  <= (o_read && mux_hit) ? mux_data : '0;
                  o_pslverr <= !mux_hit;
                  o_pready  <= 1'b1;
                  state     <= ST_RESPONSE;
               end
            end
            ST_RESPONSE: begin
               if (!i_psel || i_penable) begin
                  o_pready  <= 1'b0;
                  o_pslverr <= 1'b0;
                  o_prdata  <= '0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               o_read    <= 1'b0;
               o_write   <= 1'b0;
               o_pready  <= 1'b0;
               o_pslverr <= 1'b0;
               o_prdata  <= '0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rgen_host_if_apb.sv
// ---------------------------------------------------------------------------
// tb_rgen_host_if_apb
// Self-checking bench for rgen_host_if_apb with four registers attached.
// An APB master task drives complete transfers (optionally aborted) and
// checks the command pulse and response against a small reference model.
// ---------------------------------------------------------------------------
module tb_rgen_host_if_apb;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int NR = 4;

   logic             clk;
   logic             rst_n;
   logic             psel;
   logic             penable;
   logic             pwrite;
   logic [AW-1:0]    paddr;
   logic [DW-1:0]    pwdata;
   logic             pready;
   logic [DW-1:0]    prdata;
   logic             pslverr;
   logic [AW-1:0]    address;
   logic             read;
   logic             write;
   logic [DW-1:0]    write_data;
   logic [NR-1:0]    reg_select;
   logic [NR*DW-1:0] reg_read_data;

   int total;
   int bad;

   rgen_host_if_apb #(
      .ADDRESS_WIDTH   (AW),
      .DATA_WIDTH      (DW),
      .TOTAL_REGISTERS (NR)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .i_psel               (psel),
      .i_penable            (penable),
      .i_pwrite             (pwrite),
      .i_paddr              (paddr),
      .i_pwdata             (pwdata),
      .o_pready             (pready),
      .o_prdata             (prdata),
      .o_pslverr            (pslverr),
      .o_address            (address),
      .o_read               (read),
      .o_write              (write),
      .o_write_data         (write_data),
      .i_register_select    (reg_select),
      .i_register_read_data (reg_read_data)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                              input logic [DW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference response: a read returns the OR of every selected register,
   // an error is raised whenever nothing is selected.
   function automatic logic [DW-1:0] model_rdata(input bit wr, input logic [NR-1:0] sel,
                                                 input logic [NR*DW-1:0] data);
      logic [DW-1:0] acc;
      acc = '0;
      if (!wr) begin
         for (int n = 0; n < NR; n++) begin
            if (sel[n]) acc = acc | data[n*DW +: DW];
         end
      end
      return acc;
   endfunction

   // One APB transfer, entered #1 after a rising edge and left #1 after the
   // last edge of the transfer with the bus idle. With abort set the master
   // drops psel during the access phase.
   task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [NR-1:0] sel,
                                input logic [NR*DW-1:0] data, input bit abort);
      psel          = 1'b1;
      penable       = 1'b0;
      pwrite        = wr;
      paddr         = addr;
      pwdata        = wdata;
      reg_select    = sel;
      reg_read_data = data;
      @(posedge clk); #1;
      checkOutput("cmd_read", 32'(read), 32'(!wr));
      checkOutput("cmd_write", 32'(write), 32'(wr));
      checkOutput("cmd_address", 32'(address), 32'(addr));
      checkOutput("cmd_wdata", write_data, wdata);
      checkOutput("cmd_pready", 32'(pready), 32'd0);
      if (abort) begin
         psel    = 1'b0;
         penable = 1'b0;
         @(posedge clk); #1;
         checkOutput("abort_strobe", 32'({read, write}), 32'd0);
         checkOutput("abort_pready", 32'(pready), 32'd0);
         return;
      end
      penable = 1'b1;
      @(posedge clk); #1;
      checkOutput("rsp_strobe", 32'({read, write}), 32'd0);
      checkOutput("rsp_pready", 32'(pready), 32'd1);
      checkOutput("rsp_prdata", prdata, model_rdata(wr, sel, data));
      checkOutput("rsp_pslverr", 32'(pslverr), 32'(sel == '0));
      @(posedge clk); #1;
      psel    = 1'b0;
      penable = 1'b0;
      checkOutput("end_pready", 32'(pready), 32'd0);
      checkOutput("end_pslverr", 32'(pslverr), 32'd0);
      checkOutput("end_prdata", prdata, 32'd0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [NR*DW-1:0] data;
      logic [NR-1:0]    sel;
      logic [AW-1:0]    last_addr;
      total         = 0;
      bad           = 0;
      rst_n         = 1'b0;
      psel          = 1'b0;
      penable       = 1'b0;
      pwrite        = 1'b0;
      paddr         = '0;
      pwdata        = '0;
      reg_select    = '0;
      reg_read_data = '0;
      idle_cycles(2);
      checkOutput("reset_outputs", 32'({pready, pslverr, read, write}), 32'd0);
      checkOutput("reset_address", 32'(address), 32'd0);
      checkOutput("reset_prdata", prdata, 32'd0);
      rst_n = 1'b1;
      idle_cycles(1);

      // Access-phase signalling without a setup phase must be ignored.
      psel    = 1'b1;
      penable = 1'b1;
      idle_cycles(2);
      checkOutput("ignore_strobe", 32'({read, write}), 32'd0);
      checkOutput("ignore_pready", 32'(pready), 32'd0);
      psel    = 1'b0;
      penable = 1'b0;
      idle_cycles(1);

      // Directed cases.
      data = {32'hAAAA0003, 32'h12345678, 32'h55550001, 32'h0F0F0000};
      applyStimulus(1'b1, 16'h0004, 32'hDEADBEEF, 4'b0010, data, 1'b0);
      idle_cycles(1);
      applyStimulus(1'b0, 16'h0008, 32'h0, 4'b0100, data, 1'b0);
      applyStimulus(1'b0, 16'h0100, 32'h0, 4'b0000, data, 1'b0);
      applyStimulus(1'b1, 16'h0104, 32'hCAFEF00D, 4'b0000, data, 1'b0);
      applyStimulus(1'b0, 16'h000C, 32'h0, 4'b1001, data, 1'b0);
      // Back-to-back write then read of the same address.
      applyStimulus(1'b1, 16'h0000, 32'h11223344, 4'b0001, data, 1'b0);
      applyStimulus(1'b0, 16'h0000, 32'h0, 4'b0001, data, 1'b0);
      // Abort followed by a normal transfer.
      applyStimulus(1'b1, 16'h0008, 32'h99887766, 4'b0100, data, 1'b1);
      applyStimulus(1'b0, 16'h0008, 32'h0, 4'b0100, data, 1'b0);

      // Reset asserted while the response is on the bus.
      psel          = 1'b1;
      penable       = 1'b0;
      pwrite        = 1'b0;
      paddr         = 16'h0004;
      reg_select    = 4'b0010;
      idle_cycles(1);
      penable = 1'b1;
      idle_cycles(1);
      checkOutput("pre_reset_pready", 32'(pready), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_flags", 32'({pready, pslverr, read, write}), 32'd0);
      checkOutput("async_reset_prdata", prdata, 32'd0);
      psel    = 1'b0;
      penable = 1'b0;
      #1;
      rst_n = 1'b1;
      idle_cycles(1);
      checkOutput("post_reset_idle", 32'({pready, read, write}), 32'd0);
      applyStimulus(1'b0, 16'h0004, 32'h0, 4'b0010, data, 1'b0);

      // Randomized transfers, including misses, overlaps, aborts and gaps.
      last_addr = 16'h0004;
      for (int t = 0; t < 60; t++) begin
         bit wr;
         bit ab;
         logic [AW-1:0] a;
         for (int n = 0; n < NR; n++) data[n*DW +: DW] = $urandom;
         sel = 4'($urandom_range(0, 15));
         wr  = 1'($urandom_range(0, 1));
         ab  = ($urandom_range(0, 7) == 0);
         a   = 16'($urandom);
         applyStimulus(wr, a, $urandom, sel, data, ab);
         last_addr = a;
         idle_cycles($urandom_range(0, 2));
         checkOutput("hold_address", 32'(address), 32'(last_addr));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
